aes_share_sched: RTL and testbench

//  Time-multiplexes one aes_128 core between two requesters: port 0 = system bus, port 1 = random fuzzer.

---
 rtl/aes_sched_pkg.sv | 7 +
 rtl/aes_share_sched_if.sv | 23 ++
 rtl/rr_arb2.sv | 19 +
 rtl/aes_share_sched.sv | 125 ++++++++++++
 tb/tb_aes_share_sched.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and widths for the AES core share scheduler.
package aes_sched_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    typedef enum logic {PORT_BUS = 1'b0, PORT_FUZZ = 1'b1} port_t;
    localparam int AES_IN_W  = 256;
    localparam int AES_OUT_W = 128;
endpackage

// File: rtl/aes_share_sched_if.sv
// Requester-side job/result handshake bundle for two ports sharing one AES core.
interface aes_share_sched_if #(
    parameter int IN_W  = 256,
    parameter int OUT_W = 128
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*IN_W-1:0] req_data;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [OUT_W-1:0]  rsp_data;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; purely combinational, pointer breaks ties.
// No state, no backpressure: the caller owns the pointer.
module rr_arb2
    import aes_sched_pkg::*;
(
    input  logic [1:0] eligible,
    input  port_t      ptr,
    output logic       gnt_vld,
    output port_t      gnt
);
    always_comb begin
        gnt_vld = |eligible;
        gnt     = PORT_BUS;
        if (eligible == 2'b11)
            gnt = ptr;
        else if (eligible[1])
            gnt = PORT_FUZZ;
    end
endmodule

// File: rtl/aes_share_sched.sv
// Shares one AES core between the bus (port 0) and the fuzzer (port 1) with a hang watchdog.
// Accept -> start next cycle -> result one cycle after core strobe; result held until owner's ready.
module aes_share_sched
    import aes_sched_pkg::*;
#(
    parameter int IN_W    = AES_IN_W,
    parameter int OUT_W   = AES_OUT_W,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fuzz_en,
    aes_share_sched_if.slave rq,
    output logic             aes_start,
    output logic [IN_W-1:0]  aes_in,
    input  logic [OUT_W-1:0] aes_out,
    input  logic             aes_out_valid,
    output logic             busy,
    output logic             owner,
    output logic             alarm_timeout,
    output logic [CNT_W-1:0] job_count,
    output logic [CNT_W-1:0] stray_count
);
    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    state_t            state, state_nxt;
    port_t             owner_q, rr_q, gnt;
    logic              gnt_vld;
    logic [1:0]        eligible;
    logic [WD_W-1:0]   wd;
    logic              wd_hit;
    logic              own_rdy;
    logic [OUT_W-1:0]  rsp_data_q;
    logic              rsp_err_q;

    assign eligible = rq.req_valid & {fuzz_en, 1'b1};
    // wd counts WAIT cycles already spent; the last allowed one aborts unless the core answers.
    assign wd_hit   = (wd == WD_W'(TIMEOUT - 1));
    assign own_rdy  = (owner_q == PORT_FUZZ) ? rq.rsp_ready[1] : rq.rsp_ready[0];

    rr_arb2 u_arb (
        .eligible (eligible),
        .ptr      (rr_q),
        .gnt_vld  (gnt_vld),
        .gnt      (gnt)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (gnt_vld) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (aes_out_valid || wd_hit) state_nxt = RESP;
            RESP:  if (own_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rq.req_ready = 2'b00;
        if (state == IDLE && gnt_vld)
            rq.req_ready = {gnt == PORT_FUZZ, gnt == PORT_BUS};
        rq.rsp_valid = 2'b00;
        if (state == RESP)
            rq.rsp_valid = {owner_q == PORT_FUZZ, owner_q == PORT_BUS};
        rq.rsp_data = rsp_data_q;
        rq.rsp_err  = rsp_err_q;
        aes_start   = (state == ISSUE);
        busy        = (state != IDLE);
        owner       = owner_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_in        <= '0;
            owner_q       <= PORT_BUS;
            rr_q          <= PORT_BUS;
            wd            <= '0;
            rsp_data_q    <= '0;
            rsp_err_q     <= 1'b0;
            alarm_timeout <= 1'b0;
            job_count     <= '0;
            stray_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        aes_in  <= (gnt == PORT_FUZZ) ? rq.req_data[2*IN_W-1:IN_W]
                                                      : rq.req_data[IN_W-1:0];
                        owner_q <= gnt;
                    end
                end
                ISSUE: wd <= '0;
                WAIT: begin
                    wd <= wd + WD_W'(1);
                    if (aes_out_valid) begin
                        rsp_data_q <= aes_out;
                        rsp_err_q  <= 1'b0;
                    end else if (wd_hit) begin
                        rsp_data_q    <= '0;
                        rsp_err_q     <= 1'b1;
                        alarm_timeout <= 1'b1;
                    end
                end
                RESP: begin
                    if (own_rdy) begin
                        job_count <= job_count + CNT_W'(1);
                        rr_q      <= (owner_q == PORT_BUS) ? PORT_FUZZ : PORT_BUS;
                    end
                end
                default: ;
            endcase
            if (aes_out_valid && state != WAIT && stray_count != '1)
                stray_count <= stray_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_aes_share_sched.sv
// Directed + randomized bench for aes_share_sched with a delayed-response core model.
module tb_aes_share_sched;
    localparam int TIMEOUT = 64;
    localparam logic [255:0] KAT_IN  = {128'h000102030405060708090a0b0c0d0e0f,
                                        128'h00112233445566778899aabbccddeeff};
    localparam logic [127:0] KAT_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst, fuzz_en;
    logic         aes_start, aes_out_valid;
    logic [255:0] aes_in;
    logic [127:0] aes_out;
    logic         busy, owner, alarm_timeout;
    logic [15:0]  job_count, stray_count;

    aes_share_sched_if #(.IN_W(256), .OUT_W(128)) rq ();

    aes_share_sched #(.IN_W(256), .OUT_W(128), .TIMEOUT(TIMEOUT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .fuzz_en(fuzz_en), .rq(rq),
        .aes_start(aes_start), .aes_in(aes_in), .aes_out(aes_out),
        .aes_out_valid(aes_out_valid), .busy(busy), .owner(owner),
        .alarm_timeout(alarm_timeout), .job_count(job_count), .stray_count(stray_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int job_m = 0, stray_m = 0;
    bit alarm_m = 0, rr_m = 0;
    int core_lat = 10;
    int stray_req = 0;

    // Stand-in core: knows the FIPS-197 answer, otherwise a fixed scramble of its input.
    function automatic logic [127:0] core_fn(input logic [255:0] x);
        if (x == KAT_IN) return KAT_OUT;
        return x[127:0] ^ {x[191:128], x[255:192]} ^ 128'ha5a5_5a5a_0f0f_f0f0_3c3c_c3c3_9696_6969;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " req_ready"}, rq.req_ready, 0);
        chk({tag, " rsp_valid"}, rq.rsp_valid, 0);
        chk({tag, " rsp_data"}, rq.rsp_data, 0);
        chk({tag, " rsp_err"}, rq.rsp_err, 0);
        chk({tag, " aes_start"}, aes_start, 0);
        chk({tag, " aes_in"}, aes_in, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " owner"}, owner, 0);
        chk({tag, " alarm"}, alarm_timeout, 0);
        chk({tag, " job_count"}, job_count, 0);
        chk({tag, " stray_count"}, stray_count, 0);
    endtask

    // lat: core latency in cycles after start (0 = never answers); hold: RESP cycles before owner ready.
    task automatic job(input string tag, input logic [1:0] vld, input logic [255:0] d0,
                       input logic [255:0] d1, input int lat, input int hold, input bit drop_fz);
        logic [1:0]   elig;
        bit           g, answered;
        logic [255:0] dg;
        logic [127:0] exp_d;
        logic [1:0]   exp_v;
        int           cyc, starts;
        core_lat = lat;
        rq.req_data  = {d1, d0};
        rq.req_valid = vld;
        #1;
        elig = vld & {fuzz_en, 1'b1};
        g = (elig == 2'b11) ? rr_m : elig[1];
        exp_v = g ? 2'b10 : 2'b01;
        dg = g ? d1 : d0;
        chk({tag, " grant"}, rq.req_ready, exp_v);
        @(negedge clk);
        chk({tag, " start"}, aes_start, 1);
        chk({tag, " owner"}, owner, g);
        chk({tag, " aes_in"}, aes_in, dg);
        chk({tag, " ready_busy"}, rq.req_ready, 0);
        if (drop_fz) fuzz_en = 1'b0;
        answered = (lat > 0 && lat <= TIMEOUT);
        exp_d = answered ? core_fn(dg) : 128'd0;
        cyc = 0;
        starts = 0;
        while (rq.rsp_valid == 2'b00 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (aes_start) starts++;
        end
        chk({tag, " latency"}, cyc, answered ? lat + 1 : TIMEOUT + 1);
        chk({tag, " extra_start"}, starts, 0);
        chk({tag, " rsp_valid"}, rq.rsp_valid, exp_v);
        chk({tag, " rsp_data"}, rq.rsp_data, exp_d);
        chk({tag, " rsp_err"}, rq.rsp_err, !answered);
        if (!answered) alarm_m = 1;
        if (lat == TIMEOUT + 1) stray_m++;
        for (int i = 0; i < hold; i++) begin
            rq.rsp_ready = ~exp_v;
            @(negedge clk);
            chk({tag, " hold_valid"}, rq.rsp_valid, exp_v);
            chk({tag, " hold_data"}, rq.rsp_data, exp_d);
            chk({tag, " hold_err"}, rq.rsp_err, !answered);
            chk({tag, " hold_nogrant"}, rq.req_ready, 0);
        end
        rq.rsp_ready = exp_v;
        @(negedge clk);
        rq.rsp_ready = 2'b00;
        rq.req_valid = 2'b00;
        job_m++;
        rr_m = ~g;
        chk({tag, " rsp_drop"}, rq.rsp_valid, 0);
        chk({tag, " idle"}, busy, 0);
        chk({tag, " job_count"}, job_count, job_m[15:0]);
        chk({tag, " stray_count"}, stray_count, stray_m);
        chk({tag, " alarm"}, alarm_timeout, alarm_m);
    endtask

    initial begin : core_model
        int cnt, served;
        logic [255:0] lat_in;
        cnt = 0;
        served = 0;
        lat_in = '0;
        aes_out_valid = 1'b0;
        aes_out = '0;
        forever begin
            @(negedge clk);
            aes_out_valid = 1'b0;
            if (served < stray_req) begin
                aes_out_valid = 1'b1;
                aes_out = {$urandom, $urandom, $urandom, $urandom};
                served++;
            end
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    aes_out_valid = 1'b1;
                    aes_out = core_fn(lat_in);
                end
            end
            if (aes_start && core_lat > 0) begin
                cnt = core_lat;
                lat_in = aes_in;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        rst = 1'b1;
        fuzz_en = 1'b0;
        rq.req_valid = 2'b00;
        rq.rsp_ready = 2'b00;
        rq.req_data = '0;
        repeat (3) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;

        stray_req++;
        repeat (3) @(negedge clk);
        stray_m++;
        chk("stray_idle", stray_count, stray_m);

        job("kat", 2'b01, KAT_IN, rnd256(), 10, 0, 0);

        rq.req_valid = 2'b10;
        repeat (20) begin
            @(negedge clk);
            chk("masked_ready", rq.req_ready, 0);
            chk("masked_busy", busy, 0);
        end
        fuzz_en = 1'b1;
        job("fuzz_unmask", 2'b10, rnd256(), rnd256(), 7, 0, 0);

        job("timeout", 2'b01, rnd256(), rnd256(), 0, 0, 0);
        job("result_at_limit", 2'b10, rnd256(), rnd256(), TIMEOUT, 0, 0);
        job("result_after_limit", 2'b01, rnd256(), rnd256(), TIMEOUT + 1, 0, 0);
        job("hold20", 2'b11, rnd256(), rnd256(), 5, 20, 0);

        for (int i = 0; i < 6; i++) begin
            fuzz_en = 1'b1;
            job("rand", 2'($urandom_range(1, 3)), rnd256(), rnd256(),
                $urandom_range(1, 12), $urandom_range(0, 3), i == 2);
        end
        fuzz_en = 1'b1;
        job("fuzz_drop", 2'b10, rnd256(), rnd256(), 4, 0, 1);
        fuzz_en = 1'b1;

        core_lat = 20;
        rq.req_data = {rnd256(), rnd256()};
        rq.req_valid = 2'b01;
        @(negedge clk);
        rq.req_valid = 2'b00;
        repeat (5) @(negedge clk);
        chk("midjob_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        job_m = 0;
        stray_m = 0;
        alarm_m = 0;
        rr_m = 0;
        chk_reset("midjob_reset");
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (rq.rsp_valid != 2'b00) seen++;
        end
        stray_m++;
        chk("midjob_no_rsp", seen, 0);
        chk("midjob_stray", stray_count, stray_m);
        chk("midjob_busy_after", busy, 0);

        for (int i = 0; i < 4; i++)
            job("both", 2'b11, rnd256(), rnd256(), $urandom_range(1, 9), 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
